// File: rtl/tinyqv_mem_responder.sv
// tinyqv_mem_responder
//
// Data-memory target for the tinyqv_core load/store port. It holds a small word-organised
// RAM and serves one request at a time. Stores are byte-lane merged and complete at the
// accept edge without a response. Loads return sign- or zero-extended data after a
// programmable latency, signalled by a one-cycle load_data_ready pulse.
//
// Parameters:
//   DEPTH_LOG2  log2 of RAM depth in 32-bit words
//   LATENCY     cycles from load accept to load_data_ready (1..15)
//
// Ports:
//   clk             clock, all state on the rising edge
//   rstn            asynchronous active-low reset
//   addr_in         byte address; only [DEPTH_LOG2+1:0] is used, upper bits alias
//   mem_op          funct3: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU (3/6/7 reserved)
//   is_store        1 store, 0 load
//   address_ready   request strobe, sampled every cycle
//   data_from_core  store data, LSB aligned
//   data_to_core    load result; holds its last value outside the response cycle
//   load_data_ready one-cycle load completion pulse
//   busy            a load is in flight
//   err_misalign    sticky: misaligned or reserved-op request seen
//   err_overlap     sticky: request arrived while busy and was dropped
//
// Build option:
//   TINYQV_MEMRESP_JITTER_EN  adds 0..3 pseudo-random extra wait cycles per load, taken from
//                             an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5).

module tinyqv_mem_responder #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [27:0] addr_in,
    input  logic [2:0]  mem_op,
    input  logic        is_store,
    input  logic        address_ready,
    input  logic [31:0] data_from_core,
    output logic [31:0] data_to_core,
    output logic        load_data_ready,
    output logic        busy,
    output logic        err_misalign,
    output logic        err_overlap
);

    localparam int unsigned Words   = 2 ** DEPTH_LOG2;
    localparam logic [4:0]  LatBase = 5'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e                  state_q, state_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [1:0]              off_q, off_d;
    logic [2:0]              op_q, op_d;
    logic                    mis_q, mis_d;
    logic [31:0]             hold_q, hold_d;
    logic                    err_mis_q, err_mis_d;
    logic                    err_ovl_q, err_ovl_d;

    logic [31:0]             mem_q [Words];

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [DEPTH_LOG2-1:0]   req_idx;
    logic [1:0]              req_off;
    logic                    req_mis;
    logic                    req_accept;
    logic                    load_accept;
    logic                    wr_en;
    logic [3:0]              wr_be;
    logic [31:0]             wr_data;
    logic                    unused_addr;

    assign req_idx     = addr_in[DEPTH_LOG2+1:2];
    assign req_off     = addr_in[1:0];
    // Upper address bits deliberately ignored so the RAM aliases.
    assign unused_addr = ^addr_in[27:DEPTH_LOG2+2];

    always_comb begin
        req_mis = 1'b1;
        case (mem_op)
            3'd0, 3'd4: req_mis = 1'b0;
            3'd1, 3'd5: req_mis = req_off[0];
            3'd2:       req_mis = |req_off;
            default:    req_mis = 1'b1;
        endcase
    end

    assign req_accept  = (state_q == StIdle) && address_ready;
    assign load_accept = req_accept && !is_store;
    assign wr_en       = req_accept && is_store && !req_mis;

    // Replicate store data across lanes; the byte enables pick the lanes to write.
    always_comb begin
        wr_be   = 4'hF;
        wr_data = data_from_core;
        case (mem_op[1:0])
            2'd0: begin
                wr_be   = 4'b0001 << req_off;
                wr_data = {4{data_from_core[7:0]}};
            end
            2'd1: begin
                wr_be   = req_off[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{data_from_core[15:0]}};
            end
            default: begin
                wr_be   = 4'hF;
                wr_data = data_from_core;
            end
        endcase
    end

    // RAM contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[req_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional latency jitter
    // ------------------------------------------------------------------
    logic [4:0] extra_wait;

`ifdef TINYQV_MEMRESP_JITTER_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic       lfsr_fb;

    assign lfsr_fb    = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    // Extra cycles come from the value before this load advances the LFSR.
    assign extra_wait = {3'b000, lfsr_q[1:0]};

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_accept) begin
            lfsr_d = {lfsr_q[6:0], lfsr_fb};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign extra_wait = 5'd0;
`endif

    // ------------------------------------------------------------------
    // Load data formatting
    // ------------------------------------------------------------------
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_fmt;

    assign rd_word = mem_q[idx_q];
    assign rd_byte = rd_word[{off_q, 3'b000} +: 8];
    assign rd_half = off_q[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_fmt = 32'd0;
        if (!mis_q) begin
            case (op_q)
                3'd0:    load_fmt = {{24{rd_byte[7]}}, rd_byte};
                3'd1:    load_fmt = {{16{rd_half[15]}}, rd_half};
                3'd2:    load_fmt = rd_word;
                3'd4:    load_fmt = {24'd0, rd_byte};
                3'd5:    load_fmt = {16'd0, rd_half};
                default: load_fmt = 32'd0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic [4:0] load_cnt;

    assign load_cnt = LatBase + extra_wait;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        off_d     = off_q;
        op_d      = op_q;
        mis_d     = mis_q;
        hold_d    = hold_q;
        err_mis_d = err_mis_q;
        err_ovl_d = err_ovl_q;

        case (state_q)
            StIdle: begin
                if (address_ready) begin
                    if (req_mis) begin
                        err_mis_d = 1'b1;
                    end
                    if (!is_store) begin
                        idx_d   = req_idx;
                        off_d   = req_off;
                        op_d    = mem_op;
                        mis_d   = req_mis;
                        cnt_d   = load_cnt;
                        state_d = (load_cnt == 5'd0) ? StResp : StWait;
                    end
                end
            end
            StWait: begin
                if (address_ready) begin
                    err_ovl_d = 1'b1;
                end
                cnt_d = cnt_q - 5'd1;
                // Counter reaching zero at this edge means the response cycle follows.
                if (cnt_q <= 5'd1) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (address_ready) begin
                    err_ovl_d = 1'b1;
                end
                hold_d  = load_fmt;
                cnt_d   = 5'd0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            cnt_q     <= 5'd0;
            idx_q     <= '0;
            off_q     <= 2'd0;
            op_q      <= 3'd0;
            mis_q     <= 1'b0;
            hold_q    <= 32'd0;
            err_mis_q <= 1'b0;
            err_ovl_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            off_q     <= off_d;
            op_q      <= op_d;
            mis_q     <= mis_d;
            hold_q    <= hold_d;
            err_mis_q <= err_mis_d;
            err_ovl_q <= err_ovl_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign load_data_ready = (state_q == StResp);
    assign busy            = (state_q != StIdle);
    assign data_to_core    = (state_q == StResp) ? load_fmt : hold_q;
    assign err_misalign    = err_mis_q;
    assign err_overlap     = err_ovl_q;

endmodule

// File: tb/tb_tinyqv_mem_responder.sv
// Randomised scoreboard bench for tinyqv_mem_responder. A byte-addressed reference memory
// predicts every load result and its response cycle; a monitor pops expectations whenever
// the DUT pulses load_data_ready, and also checks busy and the held data every cycle.

module tb_tinyqv_mem_responder;

    localparam int unsigned DepthLog2 = 8;
    localparam int unsigned Latency   = 2;
    localparam int unsigned MemBytes  = 4 << DepthLog2;

    logic        clk;
    logic        rstn;
    logic [27:0] addr_in;
    logic [2:0]  mem_op;
    logic        is_store;
    logic        address_ready;
    logic [31:0] data_from_core;
    logic [31:0] data_to_core;
    logic        load_data_ready;
    logic        busy;
    logic        err_misalign;
    logic        err_overlap;

    tinyqv_mem_responder #(
        .DEPTH_LOG2 (DepthLog2),
        .LATENCY    (Latency)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .addr_in         (addr_in),
        .mem_op          (mem_op),
        .is_store        (is_store),
        .address_ready   (address_ready),
        .data_from_core  (data_from_core),
        .data_to_core    (data_to_core),
        .load_data_ready (load_data_ready),
        .busy            (busy),
        .err_misalign    (err_misalign),
        .err_overlap     (err_overlap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [7:0]  ref_mem [MemBytes];
    int          checks = 0;
    int          errors = 0;
    int          cur_n  = 0;
    int          cur_r  = -1;
    logic [31:0] last_data = 32'd0;
    bit          exp_mis = 1'b0;
    bit          exp_ovl = 1'b0;
    bit          mon_en  = 1'b0;
    logic [7:0]  lfsr_m  = 8'hA5;

    // ---------------- reference model ----------------
    function automatic bit ref_misaligned(input logic [2:0] op, input logic [27:0] a);
        if (op == 3'd0 || op == 3'd4) return 1'b0;
        if (op == 3'd1 || op == 3'd5) return a[0];
        if (op == 3'd2) return (a % 4) != 0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [27:0] a);
        int unsigned ba;
        int unsigned v;
        ba = a % MemBytes;
        case (op)
            3'd0, 3'd4: begin
                v = ref_mem[ba];
                if (op == 3'd0 && v >= 128) v = v - 256;
            end
            3'd1, 3'd5: begin
                v = ref_mem[ba] + 256 * ref_mem[ba + 1];
                if (op == 3'd1 && v >= 32768) v = v - 65536;
            end
            default: begin
                v = ref_mem[ba] + (ref_mem[ba + 1] << 8) + (ref_mem[ba + 2] << 16)
                    + (ref_mem[ba + 3] << 24);
            end
        endcase
        return v;
    endfunction

    function automatic int ref_extra();
        int e;
        e = 0;
`ifdef TINYQV_MEMRESP_JITTER_EN
        e = lfsr_m % 4;
        lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
`endif
        return e;
    endfunction

    task automatic model_request(input bit st, input logic [2:0] op, input logic [27:0] a,
                                 input logic [31:0] d, input int e);
        int unsigned ba;
        int          nb;
        exp_t        x;
        bit          mis;
        if (cur_r >= 0 && e < cur_r + 2) begin
            exp_ovl = 1'b1;
            return;
        end
        mis = ref_misaligned(op, a);
        if (mis) exp_mis = 1'b1;
        if (st) begin
            if (!mis) begin
                nb = (op == 3'd0) ? 1 : (op == 3'd1) ? 2 : 4;
                ba = (a % MemBytes) - ((a % MemBytes) % nb);
                for (int i = 0; i < nb; i++) ref_mem[ba + i] = d[i*8 +: 8];
            end
        end else begin
            x.data = mis ? 32'd0 : ref_load(op, a);
            x.due  = e + int'(Latency) - 1 + ref_extra();
            sb_q.push_back(x);
            cur_n = e;
            cur_r = x.due;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic req(input bit st, input logic [2:0] op, input logic [27:0] a,
                       input logic [31:0] d);
        address_ready  = 1'b1;
        is_store       = st;
        mem_op         = op;
        addr_in        = a;
        data_from_core = d;
        @(posedge clk);
        #1;
        address_ready = 1'b0;
        model_request(st, op, a, d, cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb_q.size() != 0 || cyc <= cur_r + 1) && k < 60) begin
            idle(1);
            k++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses still pending, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic chk_flags(input string name);
        @(negedge clk);
        checks++;
        if (err_misalign !== exp_mis || err_overlap !== exp_ovl) begin
            errors++;
            $display("FAIL %s: flags mis=%b ovl=%b, required mis=%b ovl=%b", name,
                     err_misalign, err_overlap, exp_mis, exp_ovl);
        end
    endtask

    task automatic do_reset(input int n);
        rstn      = 1'b0;
        sb_q.delete();
        cur_r     = -1;
        last_data = 32'd0;
        exp_mis   = 1'b0;
        exp_ovl   = 1'b0;
        lfsr_m    = 8'hA5;
        repeat (n) begin
            @(negedge clk);
            checks++;
            if ({data_to_core, load_data_ready, busy, err_misalign, err_overlap} !== 36'd0) begin
                errors++;
                $display("FAIL reset_outputs: data=%h ldr=%b busy=%b mis=%b ovl=%b, required 0",
                         data_to_core, load_data_ready, busy, err_misalign, err_overlap);
            end
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en && rstn) begin
            if (load_data_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: pulse at cycle %0d data=%h, required none",
                             cyc, data_to_core);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (data_to_core !== mon_e.data || cyc != mon_e.due) begin
                        errors++;
                        $display("FAIL load_resp: data=%h cycle=%0d, required data=%h cycle=%0d",
                                 data_to_core, cyc, mon_e.data, mon_e.due);
                    end
                    last_data = mon_e.data;
                end
            end else begin
                if (sb_q.size() != 0 && sb_q[0].due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_pulse: none by cycle %0d, required at cycle %0d",
                             cyc, sb_q[0].due);
                    void'(sb_q.pop_front());
                end
                checks++;
                if (data_to_core !== last_data) begin
                    errors++;
                    $display("FAIL data_hold: data=%h at cycle %0d, required %h", data_to_core,
                             cyc, last_data);
                end
            end
            checks++;
            if (busy !== (cur_r >= 0 && cyc >= cur_n && cyc <= cur_r)) begin
                errors++;
                $display("FAIL busy: busy=%b at cycle %0d, required %b", busy, cyc,
                         (cur_r >= 0 && cyc >= cur_n && cyc <= cur_r));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        bit          st;
        logic [2:0]  op;
        logic [27:0] a;
        int          pick;

        rstn           = 1'b1;
        address_ready  = 1'b0;
        is_store       = 1'b0;
        mem_op         = 3'd0;
        addr_in        = 28'd0;
        data_from_core = 32'd0;
        @(posedge clk);
        #1;
        do_reset(3);
        mon_en = 1'b1;
        idle(2);
        chk_flags("post_reset_flags");

        // Known contents everywhere so every load has a defined answer.
        for (int i = 0; i < int'(MemBytes / 4); i++) req(1'b1, 3'd2, 28'(i * 4), $urandom);
        chk_flags("fill_flags");

        req(1'b1, 3'd2, 28'h010, 32'h876543A1);
        req(1'b0, 3'd2, 28'h010, 32'd0); drain();
        req(1'b0, 3'd0, 28'h010, 32'd0); drain();
        req(1'b0, 3'd4, 28'h010, 32'd0); drain();
        req(1'b0, 3'd1, 28'h012, 32'd0); drain();
        req(1'b0, 3'd5, 28'h012, 32'd0); drain();
        req(1'b1, 3'd0, 28'h011, 32'h0000005A);
        req(1'b0, 3'd2, 28'h010, 32'd0); drain();
        req(1'b1, 3'd2, 28'h400, 32'h00001234);
        req(1'b0, 3'd2, 28'h000, 32'd0); drain();
        chk_flags("clean_flags");

        req(1'b0, 3'd2, 28'h013, 32'd0); drain();
        chk_flags("misalign_load_flag");
        req(1'b1, 3'd1, 28'h011, 32'hFFFF_BEEF);
        req(1'b0, 3'd2, 28'h010, 32'd0); drain();

        // Back-to-back requests: the second and third land while busy.
        req(1'b0, 3'd2, 28'h010, 32'd0);
        req(1'b1, 3'd2, 28'h010, 32'hDEADBEEF);
        req(1'b0, 3'd0, 28'h000, 32'd0);
        drain();
        chk_flags("overlap_flag");
        req(1'b0, 3'd2, 28'h010, 32'd0); drain();

        // Reset while a load is waiting: its response must never appear.
        req(1'b0, 3'd2, 28'h010, 32'd0);
        do_reset(2);
        idle(12);
        chk_flags("mid_load_reset_flags");

        // Consecutive loads, each separated by the minimum idle cycle.
        for (int i = 0; i < 8; i++) begin
            req(1'b0, 3'd2, 28'(i * 4), 32'd0);
            while (cyc < cur_r + 1) idle(1);
        end
        drain();

        for (int i = 0; i < 500; i++) begin
            st   = 1'($urandom_range(0, 1));
            pick = $urandom_range(0, 15);
            if (st) op = (pick < 4) ? 3'd0 : (pick < 8) ? 3'd1 : (pick < 14) ? 3'd2 :
                         (pick == 14) ? 3'd3 : 3'd7;
            else    op = (pick < 3) ? 3'd0 : (pick < 6) ? 3'd1 : (pick < 9) ? 3'd2 :
                         (pick < 12) ? 3'd4 : (pick < 15) ? 3'd5 : 3'd6;
            a = 28'($urandom);
            if ($urandom_range(0, 3) != 0) a = a & 28'h000_003F;
            req(st, op, a, $urandom);
            idle($urandom_range(0, 3));
            if (i % 100 == 99) chk_flags("random_flags");
        end
        drain();
        chk_flags("final_flags");
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue: %0d pending, required 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tinyqv_mem_responder.md
Name: tinyqv_mem_responder

Overview:
- Data-memory responder for the tinyqv_core load/store port; it is the target end of the core's address_ready / load_data_ready handshake.
- Holds a small word-organised RAM and accepts one request at a time.
- Stores are byte-lane merged; loads return sign- or zero-extended data after a programmable latency.
- Used in core benches and small FPGA builds in place of the external QSPI memory path.

Parameters:
- DEPTH_LOG2, 8, log2 of RAM depth in 32-bit words (default 256 words = 1 KiB).
- LATENCY, 2, cycles from request accept to load_data_ready; legal range 1..15.

Ports:
- clk  input  1  clock, all state on rising edge
- rstn  input  1  asynchronous active-low reset
- addr_in  input  28  byte address from core (addr_out[27:0])
- mem_op  input  3  funct3 encoding: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU
- is_store  input  1  qualifies request: 1 store, 0 load
- address_ready  input  1  request strobe from core, sampled each cycle
- data_from_core  input  32  store data, LSB-aligned (core data_out)
- data_to_core  output  32  load result (core data_in)
- load_data_ready  output  1  one-cycle load completion pulse
- busy  output  1  load in flight
- err_misalign  output  1  sticky misaligned-access flag
- err_overlap  output  1  sticky request-while-busy flag

Behaviour:
- Reset (async, rstn low): state IDLE, data_to_core=0, load_data_ready=0, busy=0, both error flags 0, counter 0. RAM contents are not reset.
- Word index = addr_in[DEPTH_LOG2+1:2]. Upper address bits are ignored, so addresses alias modulo RAM size.
- Misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0. Reserved mem_op 3/6/7 is treated as misaligned.
- FSM states: IDLE, WAIT, RESP.
- IDLE, store with address_ready: byte-enabled write at that edge.
  - SB writes lane addr[1:0] with data[7:0].
  - SH writes lanes {addr[1],0},{addr[1],1} with data[15:0].
  - SW writes all four lanes.
  - No response pulse; state stays IDLE.
  - A misaligned store is suppressed and sets err_misalign.
- IDLE, load with address_ready: capture word index, byte offset and mem_op; counter=LATENCY-1; busy=1; go WAIT (or RESP directly when LATENCY=1).
- WAIT: counter decrements each cycle; at 0, go RESP.
- RESP (exactly one cycle): load_data_ready=1 and data_to_core valid; busy drops to 0 at the next edge; return to IDLE.
  - A request accepted at edge N produces load_data_ready high in the cycle after edge N+LATENCY-1, i.e. LATENCY cycles after accept.
- Load data formatting:
  - Byte/half selected by the captured offset, then extended.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Misaligned load returns 0, still pulses load_data_ready (so the core never hangs), and sets err_misalign.
- data_to_core holds its last value outside RESP.
- address_ready while busy=1 (WAIT or RESP): request dropped, err_overlap set, in-flight load unaffected. This includes stores.
- A new request in the same cycle busy falls is accepted normally, giving back-to-back loads with one idle cycle minimum.
- Error flags clear only on reset.
- rstn low mid-load: the response is abandoned and no load_data_ready pulse ever appears for it.

Optional Feature:
- Macro TINYQV_MEMRESP_JITTER_EN.
- Defined:
  - 8-bit Fibonacci LFSR with taps 8,6,5,4, reset to 8'hA5, advanced once per accepted load.
  - lfsr[1:0] from the pre-advance value adds 0..3 extra WAIT cycles to that load.
  - Stresses the core's tolerance of variable load latency.
- Undefined: latency is exactly LATENCY; no LFSR flops are present.

Test Plan:
- Reset: hold rstn low 3 cycles -> all outputs 0; release with no requests -> outputs stay 0.
- SW 0x8765_43A1 to addr 0x010, then LW 0x010 (LATENCY=2) -> load_data_ready pulses exactly 2 cycles after accept for 1 cycle, data_to_core=0x876543A1.
- Same word:
  - LB 0x010 -> 0xFFFFFFA1.
  - LBU 0x010 -> 0x000000A1.
  - LH 0x012 -> 0xFFFF8765.
  - LHU 0x012 -> 0x00008765.
  - SB 0x5A to 0x011, then LW -> 0x87655AA1.
- Alias: SW 0x1234 to addr 0x400 (DEPTH_LOG2=8), then LW 0x000 -> 0x00001234.
- Misaligned:
  - LW 0x013 -> pulse with data 0, err_misalign=1.
  - SH to 0x011 -> memory unchanged.
- Overlap: issue LW, then address_ready again the next cycle -> err_overlap=1, exactly one pulse, first load's data returned.
- Reset mid-load: rstn low during WAIT -> no load_data_ready pulse.
- JITTER_EN: 8 consecutive loads -> latencies equal LATENCY plus the LFSR-predicted extra cycles from seed 0xA5.
